adder_sub_pipe: RTL

ADDER_SUB_PIPE -- requirements
Module: adder_sub_pipe

---
 rtl/adder_sub_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/adder_sub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into P_STAGES chunks, with skew registers
// carrying operands forward and finished result chunks along. Define ADDER_SUB_PIPE_FLAGS_EN for V/Z flags.
module adder_sub_pipe #(
    parameter int P_WIDTH  = 32,
    parameter int P_STAGES = 4
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               inRESET_SYNC,
    input  logic               iVALID,
    output logic               oBUSY,
    input  logic               iMODE,
    input  logic               iCARRY,
    input  logic [P_WIDTH-1:0] iDATA_A,
    input  logic [P_WIDTH-1:0] iDATA_B,
    output logic               oVALID,
    input  logic               iBUSY,
    output logic [P_WIDTH-1:0] oDATA,
    output logic               oC,
    output logic               oV,
    output logic               oZ
);
    localparam int C_CHUNK = P_WIDTH / P_STAGES;
    localparam int C_LAST  = P_STAGES - 1;

    logic [P_STAGES-1:0] vld_r;
    logic [P_STAGES-1:0] vld_s;
    logic [P_STAGES-1:0] cy_r;
    logic [P_STAGES-1:0] cy_s;
    logic [P_WIDTH-1:0]  opa_r [P_STAGES];
    logic [P_WIDTH-1:0]  opa_s [P_STAGES];
    logic [P_WIDTH-1:0]  opb_r [P_STAGES];
    logic [P_WIDTH-1:0]  opb_s [P_STAGES];
    logic [P_WIDTH-1:0]  sum_r [P_STAGES];
    logic [P_WIDTH-1:0]  sum_s [P_STAGES];
    logic [C_CHUNK:0]    part_s;
    logic                stall_s;

    // The whole pipeline freezes while a valid result is refused downstream.
    always_comb begin
        stall_s = vld_r[C_LAST] & iBUSY;
    end

    // A flush cycle never reports busy, even if the output is being refused.
    assign oBUSY  = stall_s & inRESET_SYNC;
    assign oVALID = vld_r[C_LAST];
    assign oDATA  = sum_r[C_LAST];
    assign oC     = cy_r[C_LAST];

    // Next state for every stage: stage k adds chunk k using the registered carry of stage k-1.
    always_comb begin
        vld_s  = {P_STAGES{1'b0}};
        cy_s   = {P_STAGES{1'b0}};
        part_s = {(C_CHUNK+1){1'b0}};
        for (int k = 0; k < P_STAGES; k++) begin
            opa_s[k] = {P_WIDTH{1'b0}};
            opb_s[k] = {P_WIDTH{1'b0}};
            sum_s[k] = {P_WIDTH{1'b0}};
        end
        vld_s[0] = iVALID;
        opa_s[0] = iDATA_A;
        opb_s[0] = iMODE ? ~iDATA_B : iDATA_B;
        part_s   = {1'b0, iDATA_A[C_CHUNK-1:0]} + {1'b0, opb_s[0][C_CHUNK-1:0]}
                 + {{C_CHUNK{1'b0}}, iCARRY};
        sum_s[0][C_CHUNK-1:0] = part_s[C_CHUNK-1:0];
        cy_s[0]  = part_s[C_CHUNK];
        for (int k = 1; k < P_STAGES; k++) begin
            vld_s[k] = vld_r[k-1];
            opa_s[k] = opa_r[k-1];
            opb_s[k] = opb_r[k-1];
            part_s   = {1'b0, opa_r[k-1][k*C_CHUNK +: C_CHUNK]}
                     + {1'b0, opb_r[k-1][k*C_CHUNK +: C_CHUNK]}
                     + {{C_CHUNK{1'b0}}, cy_r[k-1]};
            sum_s[k] = sum_r[k-1];
            sum_s[k][k*C_CHUNK +: C_CHUNK] = part_s[C_CHUNK-1:0];
            cy_s[k]  = part_s[C_CHUNK];
        end
    end

    // Pipeline registers: async clear, synchronous flush of valid bits, hold on stall.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            vld_r <= {P_STAGES{1'b0}};
            cy_r  <= {P_STAGES{1'b0}};
            for (int k = 0; k < P_STAGES; k++) begin
                opa_r[k] <= {P_WIDTH{1'b0}};
                opb_r[k] <= {P_WIDTH{1'b0}};
                sum_r[k] <= {P_WIDTH{1'b0}};
            end
        end else if (!inRESET_SYNC) begin
            vld_r <= {P_STAGES{1'b0}};
        end else if (!stall_s) begin
            vld_r <= vld_s;
            cy_r  <= cy_s;
            for (int k = 0; k < P_STAGES; k++) begin
                opa_r[k] <= opa_s[k];
                opb_r[k] <= opb_s[k];
                sum_r[k] <= sum_s[k];
            end
        end else begin
            vld_r <= vld_r;
        end
    end

`ifdef ADDER_SUB_PIPE_FLAGS_EN
    logic ovf_s;
    logic zero_s;
    logic ovf_r;
    logic zero_r;

    // Flags are formed from the last stage's inputs so they register together with the result.
    always_comb begin
        ovf_s  = (opa_s[C_LAST][P_WIDTH-1] == opb_s[C_LAST][P_WIDTH-1])
               & (sum_s[C_LAST][P_WIDTH-1] != opa_s[C_LAST][P_WIDTH-1]);
        zero_s = (sum_s[C_LAST] == {P_WIDTH{1'b0}});
    end

    // Flag registers follow the same clear and stall rules as the result.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (inRESET_SYNC && !stall_s) begin
            ovf_r  <= ovf_s;
            zero_r <= zero_s;
        end else begin
            ovf_r  <= ovf_r;
            zero_r <= zero_r;
        end
    end

    assign oV = ovf_r;
    assign oZ = zero_r;
`else
    assign oV = 1'b0;
    assign oZ = 1'b0;
`endif

endmodule
